float_mul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output.
- Generalises the combinational FP16 multiplier:
  - configurable exponent and mantissa widths
  - round-to-nearest-even, with an optional truncate mode
  - correct handling of specials (inf, NaN, zero) and exception flags
- Sits in the TRANSFORMER datapath between operand buffers and the accumulate stage (attention scores, FFN weight multiply).

---
 rtl/float_pkg.sv | 39 +++
 rtl/float_round_pack.sv | 64 ++++++
 rtl/float_mul_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_float_mul_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and constants for the pipelined floating-point multipliers.
package float_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;

    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fclass_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Subnormal encodings are treated as zero
    function automatic fclass_e classify(
        input logic e_zero,
        input logic e_ones,
        input logic m_nz
    );
        if (e_zero) return CLS_ZERO;
        if (e_ones) return m_nz ? CLS_NAN : CLS_INF;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/float_round_pack.sv
// Final stage: rounding, overflow/underflow detection, special-case packing.
module float_round_pack
    import float_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W  = 1 + EXP_W + MAN_W,
    localparam int EW = EXP_W + 2
) (
    input  logic          sign,
    input  special_e      sp,
    input  logic [EW-1:0] exp,
    input  logic [MAN_W-1:0] man,
    input  logic          guard,
    input  logic          sticky,
    input  logic          rnd,
    output logic [W-1:0]  result,
    output logic          ovf,
    output logic          unf,
    output logic          inv
);

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

    logic           inc;
    logic [MAN_W:0] man_r;
    logic [EW-1:0]  exp_r;

    always_comb begin
        inc    = (rnd == RND_RNE) & guard & (sticky | man[0]);
        man_r  = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        exp_r  = exp + {{(EW-1){1'b0}}, man_r[MAN_W]};
        result = '0;
        ovf    = 1'b0;
        unf    = 1'b0;
        inv    = 1'b0;
        unique case (sp)
            SP_NAN: begin
                result = QNAN;
                inv    = 1'b1;
            end
            SP_INF:  result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: result = {sign, {(W-1){1'b0}}};
            default: begin
                if ($signed(exp_r) >= $signed(EMAX)) begin
                    ovf = 1'b1;
                    if (rnd == RND_TRUNC)
                        result = {sign, {(EXP_W-1){1'b1}}, 1'b0,
                                  {MAN_W{1'b1}}};
                    else
                        result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (exp_r[EW-1] || exp_r == '0) begin
                    unf    = 1'b1;
                    result = {sign, {(W-1){1'b0}}};
                end else begin
                    result = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/float_mul_pipe.sv
// Pipelined floating-point multiplier: operand register, classify,
// multiply/normalise, round/pack, with valid/ready flow control.
module float_mul_pipe
    import float_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int TAG_W = 4,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             rnd_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inv
);

    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam int BIAS = bias(EXP_W);
    localparam logic [EW-1:0] BIAS_V = EW'(BIAS);

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic             rnd;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        special_e         sp;
        logic [EW-1:0]    exp;
        logic [MAN_W-1:0] ma;
        logic [MAN_W-1:0] mb;
        logic             rnd;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic             sign;
        special_e         sp;
        logic [EW-1:0]    exp;
        logic [MAN_W-1:0] man;
        logic             guard;
        logic             sticky;
        logic             rnd;
        logic [TAG_W-1:0] tag;
    } s3_t;

    typedef struct packed {
        logic [W-1:0]     result;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             unf;
        logic             inv;
    } out_t;

    logic v1_q, v2_q, v3_q, v4_q;
    logic v1_d, v2_d, v3_d, v4_d;
    logic ld1, ld2, ld3, ld4;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s3_t  s3_q, s3_d;
    out_t out_q, out_d;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    fclass_e          ca, cb;
    logic [PW-1:0]    prod;
    logic [PW-2:0]    norm;
    logic [W-1:0]     rp_result;
    logic             rp_ovf, rp_unf, rp_inv;

    // A stage loads when empty or when its successor is moving on
    always_comb begin
        ld4  = ~v4_q | out_ready;
        ld3  = ~v3_q | ld4;
        ld2  = ~v2_q | ld3;
        ld1  = ~v1_q | ld2;
        v1_d = ld1 ? in_valid : v1_q;
        v2_d = ld2 ? v1_q : v2_q;
        v3_d = ld3 ? v2_q : v3_q;
        v4_d = ld4 ? v3_q : v4_q;
        s1_d = s1_q;
        if (ld1 && in_valid) begin
            s1_d.a   = a;
            s1_d.b   = b;
            s1_d.rnd = rnd_mode;
            s1_d.tag = in_tag;
        end
    end

    always_comb begin
        ea   = s1_q.a[W-2 -: EXP_W];
        eb   = s1_q.b[W-2 -: EXP_W];
        fa   = s1_q.a[MAN_W-1:0];
        fb   = s1_q.b[MAN_W-1:0];
        ca   = classify(ea == '0, &ea, |fa);
        cb   = classify(eb == '0, &eb, |fb);
        s2_d = s2_q;
        if (ld2 && v1_q) begin
            s2_d.sign = s1_q.a[W-1] ^ s1_q.b[W-1];
            s2_d.exp  = {2'b00, ea} + {2'b00, eb} - BIAS_V;
            s2_d.ma   = fa;
            s2_d.mb   = fb;
            s2_d.rnd  = s1_q.rnd;
            s2_d.tag  = s1_q.tag;
            if (ca == CLS_NAN || cb == CLS_NAN ||
                (ca == CLS_INF && cb == CLS_ZERO) ||
                (ca == CLS_ZERO && cb == CLS_INF))
                s2_d.sp = SP_NAN;
            else if (ca == CLS_INF || cb == CLS_INF)
                s2_d.sp = SP_INF;
            else if (ca == CLS_ZERO || cb == CLS_ZERO)
                s2_d.sp = SP_ZERO;
            else
                s2_d.sp = SP_NONE;
        end
    end

    // norm holds the product with the leading one at bit PW-2 dropped
    always_comb begin
        prod = {{(MAN_W+1){1'b0}}, 1'b1, s2_q.ma} *
               {{(MAN_W+1){1'b0}}, 1'b1, s2_q.mb};
        norm = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        s3_d = s3_q;
        if (ld3 && v2_q) begin
            s3_d.sign   = s2_q.sign;
            s3_d.sp     = s2_q.sp;
            s3_d.exp    = s2_q.exp + {{(EW-1){1'b0}}, prod[PW-1]};
            s3_d.man    = norm[PW-2 -: MAN_W];
            s3_d.guard  = norm[MAN_W];
            s3_d.sticky = |norm[MAN_W-1:0];
            s3_d.rnd    = s2_q.rnd;
            s3_d.tag    = s2_q.tag;
        end
    end

    float_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign   (s3_q.sign),
        .sp     (s3_q.sp),
        .exp    (s3_q.exp),
        .man    (s3_q.man),
        .guard  (s3_q.guard),
        .sticky (s3_q.sticky),
        .rnd    (s3_q.rnd),
        .result (rp_result),
        .ovf    (rp_ovf),
        .unf    (rp_unf),
        .inv    (rp_inv)
    );

    always_comb begin
        out_d = out_q;
        if (ld4 && v3_q) begin
            out_d.result = rp_result;
            out_d.tag    = s3_q.tag;
            out_d.ovf    = rp_ovf;
            out_d.unf    = rp_unf;
            out_d.inv    = rp_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            out_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            v4_q  <= v4_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            out_q <= out_d;
        end
    end

    assign in_ready  = ld1;
    assign out_valid = v4_q;
    assign result    = out_q.result;
    assign out_tag   = out_q.tag;
    assign flag_ovf  = out_q.ovf;
    assign flag_unf  = out_q.unf;
    assign flag_inv  = out_q.inv;

endmodule

// File: tb/tb_float_mul_pipe.sv
// Scoreboard bench for float_mul_pipe (FP16 configuration).
module tb_float_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        rnd_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  out_tag;
    logic        flag_ovf, flag_unf, flag_inv;

    always #5 clk = ~clk;

    float_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inv  (flag_inv)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;
    bit   stall_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input string det);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, det);
    endtask

    // flg = {ovf, unf, inv}
    task automatic send(input logic [15:0] va, input logic [15:0] vb,
                        input logic r, input logic [3:0] t,
                        input logic [15:0] er, input logic [2:0] ef,
                        input bit lat);
        int k;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        rnd_mode = r;
        in_tag   = t;
        #1;
        k = 0;
        while (!in_ready && k < 100) begin
            stall_seen = 1'b1;
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0,
                $sformatf("tag %0d never accepted", t));
        end else begin
            e.res = er;
            e.tag = t;
            e.flg = ef;
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, sb.size() == 0,
            $sformatf("%0d results outstanding, required 0", sb.size()));
    endtask

    // Monitor: compares every output transfer against the scoreboard
    initial begin : monitor
        bit          held = 1'b0;
        logic [22:0] hv;
        logic [22:0] cur;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            cur = {result, out_tag, flag_ovf, flag_unf, flag_inv};
            if (!rst_n) begin
                held = 1'b0;
            end else if (!out_valid) begin
                if (held)
                    chk("valid_hold", 1'b0,
                        "out_valid dropped while stalled");
                held = 1'b0;
            end else begin
                if (held)
                    chk("stable", cur == hv,
                        $sformatf("got %h, held %h", cur, hv));
                if (sb.size() == 0) begin
                    chk("unexpected", 1'b0,
                        $sformatf("stray result %h tag %0d", result, out_tag));
                end else begin
                    e = sb[0];
                    if (!held && e.lat)
                        chk("latency", cyc - e.acc == 3,
                            $sformatf("tag %0d latency %0d, required 3",
                                      e.tag, cyc - e.acc));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        chk("result",
                            result == e.res && out_tag == e.tag &&
                            {flag_ovf, flag_unf, flag_inv} == e.flg,
                            $sformatf("got %h tag %0d flg %b, required %h tag %0d flg %b",
                                      result, out_tag,
                                      {flag_ovf, flag_unf, flag_inv},
                                      e.res, e.tag, e.flg));
                    end
                end
                held = !out_ready;
                hv   = cur;
            end
        end
    end

    vec_t vecs[13] = '{
        '{16'h3C00, 16'h4000, 1'b0, 16'h4000, 3'b000},
        '{16'hC000, 16'h3C00, 1'b0, 16'hC000, 3'b000},
        '{16'h3E00, 16'h3E00, 1'b0, 16'h4080, 3'b000},
        '{16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 3'b000},
        '{16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 3'b000},
        '{16'h3C01, 16'h3C01, 1'b0, 16'h3C02, 3'b000},
        '{16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 3'b100},
        '{16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 3'b100},
        '{16'h0400, 16'h0400, 1'b0, 16'h0000, 3'b010},
        '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 3'b001},
        '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b001},
        '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 3'b000},
        '{16'h8000, 16'h4000, 1'b0, 16'h8000, 3'b000}
    };

    initial begin : stim
        logic [15:0] bv;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        rnd_mode   = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b1;
        stall_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_state",
            !out_valid && result == 16'h0 && out_tag == 4'h0 &&
            !flag_ovf && !flag_unf && !flag_inv && in_ready,
            $sformatf("ov %b res %h tag %0d flg %b ir %b, required 0 0 0 000 1",
                      out_valid, result, out_tag,
                      {flag_ovf, flag_unf, flag_inv}, in_ready));

        for (int i = 0; i < 13; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].rnd, 4'(i),
                 vecs[i].res, vecs[i].flg, 1'b1);
        idle();
        drain("drain_vectors");

        stall_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bv = 16'h4000 | 16'(i);
                    send(16'h3C00, bv, 1'b0, 4'(i), bv, 3'b000, 1'b0);
                end
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk("in_ready_drop", stall_seen == 1'b1,
            "in_ready never dropped under backpressure");

        for (int i = 0; i < 3; i++)
            send(16'h3C00, 16'h4000, 1'b0, 4'(i), 16'h4000, 3'b000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_reset",
            !out_valid && result == 16'h0 && in_ready,
            $sformatf("ov %b res %h ir %b, required 0 0000 1",
                      out_valid, result, in_ready));
        repeat (10) @(negedge clk);

        send(16'h3E00, 16'h3E00, 1'b0, 4'hA, 16'h4080, 3'b000, 1'b1);
        idle();
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
